// File: rtl/accel_pkg.sv
`default_nettype none
// ============================================================================
// Module      : accel_pkg
// Description : Shared widths and LED-bar helper for the accelerometer filter.
// Revision    : 1.0 - initial release
// ============================================================================
package accel_pkg;

  localparam int DATA_W     = 16;
  localparam int AVG_LOG2   = 3;
  localparam int LED_N      = 10;
  localparam int LED_SHIFT  = 6;
  localparam int LED_CENTER = 5;

  // One-hot tilt bar: one LED step per 2**LED_SHIFT LSB, centred on LED_CENTER.
  function automatic logic [LED_N-1:0] led_onehot(input logic signed [31:0] avg);
    logic signed [31:0] idx;
    idx = (avg >>> LED_SHIFT) + LED_CENTER;
    if (idx < 0) begin
      idx = 0;
    end else if (idx > LED_N - 1) begin
      idx = LED_N - 1;
    end
    return LED_N'(1) << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/accel_axis_avg.sv
`default_nettype none
// ============================================================================
// Module      : accel_axis_avg
// Description : One-axis moving average: ring buffer plus running sum.
// Revision    : 1.0 - initial release
// ============================================================================
module accel_axis_avg #(
  parameter int DATA_W   = accel_pkg::DATA_W,
  parameter int AVG_LOG2 = accel_pkg::AVG_LOG2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_accept,
  input  logic                       i_full,
  input  logic [AVG_LOG2-1:0]        i_wr_ptr,
  input  logic signed [DATA_W-1:0]   i_sample,
  output logic signed [DATA_W-1:0]   o_avg_next
);

  localparam int c_depth = 1 << AVG_LOG2;
  localparam int c_sum_w = DATA_W + AVG_LOG2;

  logic signed [DATA_W-1:0]  r_ring [c_depth];
  logic signed [c_sum_w-1:0] r_sum;
  logic signed [DATA_W-1:0]  w_oldest;
  logic signed [c_sum_w-1:0] w_sum_next;

  // Entries not yet written during warm-up contribute nothing to the sum.
  assign w_oldest   = i_full ? r_ring[i_wr_ptr] : '0;
  assign w_sum_next = r_sum
                    + {{AVG_LOG2{i_sample[DATA_W-1]}}, i_sample}
                    - {{AVG_LOG2{w_oldest[DATA_W-1]}}, w_oldest};

  // Upper slice of the sum is the floor (arithmetic) shift by AVG_LOG2.
  assign o_avg_next = w_sum_next[c_sum_w-1:AVG_LOG2];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sum <= '0;
      for (int i = 0; i < c_depth; i++) begin
        r_ring[i] <= '0;
      end
    end else if (i_accept) begin
      r_ring[i_wr_ptr] <= i_sample;
      r_sum            <= w_sum_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/accel_sample_filter.sv
`default_nettype none
// ============================================================================
// Module      : accel_sample_filter
// Description : 3-axis moving-average filter with valid/ready and LED tilt bar.
// Revision    : 1.0 - initial release
// ============================================================================
module accel_sample_filter #(
  parameter int DATA_W   = accel_pkg::DATA_W,
  parameter int AVG_LOG2 = accel_pkg::AVG_LOG2
) (
  input  logic                        clk_clk,
  input  logic                        reset_reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_x,
  input  logic [DATA_W-1:0]           in_y,
  input  logic [DATA_W-1:0]           in_z,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_x,
  output logic [DATA_W-1:0]           out_y,
  output logic [DATA_W-1:0]           out_z,
  output logic [accel_pkg::LED_N-1:0] led_bar
);

  import accel_pkg::led_onehot;
  import accel_pkg::LED_N;

  localparam int c_axes = 3;

  logic                      w_accept;
  logic                      w_full;
  logic                      w_full_after;
  logic [AVG_LOG2-1:0]       r_wr_ptr;
  logic [AVG_LOG2:0]         r_fill;
  logic signed [DATA_W-1:0]  w_in  [c_axes];
  logic signed [DATA_W-1:0]  w_avg [c_axes];
  logic [LED_N-1:0]          w_led;

  assign in_ready = !out_valid || out_ready;
  assign w_accept = in_valid && in_ready;

  // Fill counter saturates at 2**AVG_LOG2, so its MSB alone means "full".
  assign w_full       = r_fill[AVG_LOG2];
  assign w_full_after = w_full || (&r_fill[AVG_LOG2-1:0]);

  assign w_in[0] = in_x;
  assign w_in[1] = in_y;
  assign w_in[2] = in_z;

  for (genvar a = 0; a < c_axes; a++) begin : g_axis
    accel_axis_avg #(
      .DATA_W   (DATA_W),
      .AVG_LOG2 (AVG_LOG2)
    ) u_axis (
      .clk        (clk_clk),
      .rst        (reset_reset),
      .i_accept   (w_accept),
      .i_full     (w_full),
      .i_wr_ptr   (r_wr_ptr),
      .i_sample   (w_in[a]),
      .o_avg_next (w_avg[a])
    );
  end

  assign w_led = led_onehot(32'(w_avg[0]));

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      r_wr_ptr <= '0;
      r_fill   <= '0;
    end else if (w_accept) begin
      r_wr_ptr <= r_wr_ptr + AVG_LOG2'(1);
      if (!w_full) begin
        r_fill <= r_fill + (AVG_LOG2 + 1)'(1);
      end
    end
  end

  // A new average replaces the held one in the same cycle it is consumed.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      out_valid <= 1'b0;
      out_x     <= '0;
      out_y     <= '0;
      out_z     <= '0;
      led_bar   <= '0;
    end else if (w_accept && w_full_after) begin
      out_valid <= 1'b1;
      out_x     <= w_avg[0];
      out_y     <= w_avg[1];
      out_z     <= w_avg[2];
      led_bar   <= w_led;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_accel_sample_filter.sv
`default_nettype none
// ============================================================================
// Module      : tb_accel_sample_filter
// Description : Self-checking bench with a queue-based moving-average model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_accel_sample_filter;

  localparam int W = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic signed [W-1:0] in_x, in_y, in_z;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_x, out_y, out_z;
  logic [9:0]          led_bar;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  accel_sample_filter #(.DATA_W(W), .AVG_LOG2(3)) dut (
    .clk_clk     (clk),
    .reset_reset (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_x        (in_x),
    .in_y        (in_y),
    .in_z        (in_z),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_x       (out_x),
    .out_y       (out_y),
    .out_z       (out_z),
    .led_bar     (led_bar)
  );

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d, required %0d", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {int x; int y; int z;} samp_t;
  samp_t hist[$];
  int    n_acc;
  bit    exp_valid;
  int    exp_x, exp_y, exp_z, exp_led;
  bit    m_rdy;
  int    sx, sy, sz;

  function automatic int floordiv(input int a, input int b);
    int q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic int led_exp(input int avg);
    int idx;
    idx = floordiv(avg, 64) + 5;
    if (idx < 0) idx = 0;
    if (idx > 9) idx = 9;
    return 1 << idx;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      hist.delete();
      n_acc = 0; exp_valid = 1'b0;
      exp_x = 0; exp_y = 0; exp_z = 0; exp_led = 0;
    end else begin
      m_rdy = !exp_valid || out_ready;
      if (in_valid && m_rdy) begin
        hist.push_back('{int'(in_x), int'(in_y), int'(in_z)});
        if (hist.size() > 8) void'(hist.pop_front());
        n_acc++;
        if (n_acc >= 8) begin
          sx = 0; sy = 0; sz = 0;
          foreach (hist[i]) begin
            sx += hist[i].x; sy += hist[i].y; sz += hist[i].z;
          end
          exp_valid = 1'b1;
          exp_x = floordiv(sx, 8);
          exp_y = floordiv(sy, 8);
          exp_z = floordiv(sz, 8);
          exp_led = led_exp(exp_x);
        end
      end else if (out_ready) begin
        exp_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready",  in_ready,  (!exp_valid || out_ready));
      check("out_valid", out_valid, exp_valid);
      check("out_x",     out_x,     exp_x);
      check("out_y",     out_y,     exp_y);
      check("out_z",     out_z,     exp_z);
      check("led_bar",   led_bar,   exp_led);
    end
  end

  // ---------------- stimulus ----------------
  task automatic send(input int x, input int y, input int z);
    bit got = 1'b0;
    in_valid = 1'b1;
    in_x = W'(x); in_y = W'(y); in_z = W'(z);
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    n_cmp++;
    if (!got) begin
      n_bad++;
      $display("FAIL send_timeout: actual in_ready=0 for 200 cycles, required 1");
    end
  endtask

  function automatic logic signed [W-1:0] rand_sample();
    case ($urandom_range(0, 3))
      0:       return W'($urandom);
      1:       return 16'sh7FFF;
      2:       return 16'sh8000;
      default: return W'(int'($urandom_range(0, 1200)) - 600);
    endcase
  endfunction

  task automatic pulse_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  int step_led[4] = '{64, 256, 512, 512};
  int v;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    in_x = '0; in_y = '0; in_z = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_en = 1'b1;
    check("rst_out_valid", out_valid, 0);
    check("rst_led_bar",   led_bar,   0);
    check("rst_out_x",     out_x,     0);
    rst = 1'b0;

    // warm-up
    for (int i = 1; i <= 8; i++) begin
      send(100, -100, 256);
      if (i < 8) check("warm_no_valid", out_valid, 0);
    end
    check("warm_valid", out_valid, 1);
    check("warm_x", out_x, 100);
    check("warm_y", out_y, -100);
    check("warm_z", out_z, 256);
    check("warm_led", led_bar, 64);
    check("model_warm_x", exp_x, 100);

    // step response from a settled zero window
    for (int i = 0; i < 8; i++) send(0, 0, 0);
    for (int k = 1; k <= 4; k++) begin
      send(800, 0, 0);
      check("step_x", out_x, 100 * k);
      check("step_led", led_bar, step_led[k-1]);
    end

    // backpressure
    send(10, 20, 30);
    out_ready = 1'b0;
    in_valid = 1'b1; in_x = 16'sd1234; in_y = -16'sd77; in_z = 16'sd5;
    repeat (5) begin
      @(negedge clk);
      check("bp_in_ready", in_ready, 0);
      check("bp_out_valid", out_valid, 1);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 6; i++) send(rand_sample(), rand_sample(), rand_sample());

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      in_x = rand_sample(); in_y = rand_sample(); in_z = rand_sample();
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;

    // wrap and extremes
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      v = (i % 2 == 0) ? 32767 : -32768;
      send(v, v, v);
      if (i >= 7) begin
        check("wrap_x", out_x, -1);
        check("wrap_z", out_z, -1);
        check("wrap_led", led_bar, 16);
      end
    end
    for (int i = 0; i < 8; i++) send(-32768, -32768, -32768);
    check("min_x", out_x, -32768);
    check("min_y", out_y, -32768);
    check("min_led", led_bar, 1);
    for (int i = 0; i < 8; i++) send(32767, 32767, 32767);
    check("max_x", out_x, 32767);

    // reset in the same cycle as an accept
    pulse_reset();
    for (int i = 0; i < 12; i++) send(rand_sample(), rand_sample(), rand_sample());
    in_valid = 1'b1; in_x = 16'sd5000; in_y = 16'sd5000; in_z = 16'sd5000;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_led", led_bar, 0);
    for (int i = 1; i <= 8; i++) begin
      send(64 * i, -1, (i == 1) ? 1000 : 0);
      if (i < 8) check("mid_rst_no_valid", out_valid, 0);
    end
    check("post_rst_valid", out_valid, 1);
    check("post_rst_x", out_x, 288);
    check("post_rst_y", out_y, -1);
    check("post_rst_z", out_z, 125);
    check("post_rst_led", led_bar, 512);

    repeat (3) @(posedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual simulation still running, required finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
